// File: rtl/ball_collision_detector_if.sv
// Ball-collision bundle: per-class collision pulses plus the edge code
// of the highest-priority hit, from the detector to the ball controller.
interface ball_collision_if;
    logic       collisionBallFrame;
    logic       collisionBallObstacle;
    logic       collisionBallSpring;
    logic       collisionBallFlipper;
    logic       collisionBallBumper;
    logic       collisionBallCredit;
    logic [3:0] hitEdgeCode;

    modport master (
        output collisionBallFrame,
        output collisionBallObstacle,
        output collisionBallSpring,
        output collisionBallFlipper,
        output collisionBallBumper,
        output collisionBallCredit,
        output hitEdgeCode
    );

    modport slave (
        input collisionBallFrame,
        input collisionBallObstacle,
        input collisionBallSpring,
        input collisionBallFlipper,
        input collisionBallBumper,
        input collisionBallCredit,
        input hitEdgeCode
    );
endinterface

// File: rtl/ball_collision_detector.sv
// Accumulates per-frame ball/object overlaps and emits one registered
// collision pulse per class after the next startOfFrame.
module ball_collision_detector #(
    parameter int BALL_SIZE      = 16,
    parameter int EDGE_MARGIN    = 3,
    parameter int MIN_HIT_PIXELS = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             pause,
    input  logic             reset_level,
    input  logic             ballDrawingRequest,
    input  logic [5:0]       ballOffsetX,
    input  logic [5:0]       ballOffsetY,
    input  logic             frameDR,
    input  logic             obstacleDR,
    input  logic             springDR,
    input  logic             flipperDR,
    input  logic             bumperDR,
    input  logic             creditDR,
    ball_collision_if.master coll_o
);

    localparam logic [6:0] MARGIN  = 7'(EDGE_MARGIN);
    localparam logic [6:0] FAR_LIM = 7'(BALL_SIZE - EDGE_MARGIN);
    localparam logic [7:0] MIN_HIT = 8'(MIN_HIT_PIXELS);

    // Class index 0 is the highest priority (frame), 5 the lowest (credit).
    logic [5:0]      dr;
    logic [5:0]      ovl;
    logic [3:0]      pix_edge;
    logic [5:0]      hit;
    logic [3:0]      sel_edge;

    logic [5:0][7:0] count_q, count_d;
    logic [5:0][3:0] edge_q, edge_d;
    logic [5:0]      emit_q, emit_d;
    logic [3:0]      hit_edge_q, hit_edge_d;

    assign dr  = {creditDR, bumperDR, flipperDR,
                  springDR, obstacleDR, frameDR};
    assign ovl = {6{ballDrawingRequest}} & dr;

    assign pix_edge = {({1'b0, ballOffsetX} <  MARGIN),
                       ({1'b0, ballOffsetY} <  MARGIN),
                       ({1'b0, ballOffsetX} >= FAR_LIM),
                       ({1'b0, ballOffsetY} >= FAR_LIM)};

    always_comb begin
        count_d    = count_q;
        edge_d     = edge_q;
        emit_d     = '0;
        hit_edge_d = hit_edge_q;
        hit        = '0;
        sel_edge   = '0;
        if (!pause) begin
            if (startOfFrame) begin
                for (int c = 0; c < 6; c++) begin
                    hit[c] = (count_q[c] >= MIN_HIT);
                end
                // Walk lowest to highest priority so the highest hit wins.
                for (int c = 5; c >= 0; c--) begin
                    if (hit[c]) sel_edge = edge_q[c];
                end
                emit_d = hit;
                if (|hit) hit_edge_d = sel_edge;
                count_d = '0;
                edge_d  = '0;
            end else begin
                for (int c = 0; c < 6; c++) begin
                    if (ovl[c]) begin
                        if (count_q[c] != 8'hFF) count_d[c] = count_q[c] + 8'd1;
                        edge_d[c] = edge_q[c] | pix_edge;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || reset_level) begin
            count_q    <= '0;
            edge_q     <= '0;
            emit_q     <= '0;
            hit_edge_q <= '0;
        end else begin
            count_q    <= count_d;
            edge_q     <= edge_d;
            emit_q     <= emit_d;
            hit_edge_q <= hit_edge_d;
        end
    end

    // A pause arriving in the output cycle swallows the pulse.
    assign coll_o.collisionBallFrame    = emit_q[0] & ~pause;
    assign coll_o.collisionBallObstacle = emit_q[1] & ~pause;
    assign coll_o.collisionBallSpring   = emit_q[2] & ~pause;
    assign coll_o.collisionBallFlipper  = emit_q[3] & ~pause;
    assign coll_o.collisionBallBumper   = emit_q[4] & ~pause;
    assign coll_o.collisionBallCredit   = emit_q[5] & ~pause;
    assign coll_o.hitEdgeCode           = hit_edge_q;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Directed, table-driven bench for ball_collision_detector.
module tb_ball_collision_detector;

    // dr/ec bit order: 0 frame,1 obstacle,2 spring,3 flipper,4 bumper,5 credit
    typedef struct packed {
        logic       sof;
        logic       pau;
        logic       rl;
        logic       bdr;
        logic [5:0] x;
        logic [5:0] y;
        logic [5:0] dr;
        logic [5:0] ec;
        logic [3:0] ee;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, pause, reset_level;
    logic       ballDrawingRequest;
    logic [5:0] ballOffsetX, ballOffsetY;
    logic       frameDR, obstacleDR, springDR;
    logic       flipperDR, bumperDR, creditDR;
    logic [5:0] act;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [$];

    ball_collision_if coll ();

    ball_collision_detector dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .pause              (pause),
        .reset_level        (reset_level),
        .ballDrawingRequest (ballDrawingRequest),
        .ballOffsetX        (ballOffsetX),
        .ballOffsetY        (ballOffsetY),
        .frameDR            (frameDR),
        .obstacleDR         (obstacleDR),
        .springDR           (springDR),
        .flipperDR          (flipperDR),
        .bumperDR           (bumperDR),
        .creditDR           (creditDR),
        .coll_o             (coll)
    );

    always #5 clk = ~clk;

    assign act = {coll.collisionBallCredit, coll.collisionBallBumper,
                  coll.collisionBallFlipper, coll.collisionBallSpring,
                  coll.collisionBallObstacle, coll.collisionBallFrame};

    function automatic vec_t mk(input logic sof, input logic pau,
                                input logic rl, input logic bdr,
                                input int x, input int y,
                                input logic [5:0] dr,
                                input logic [5:0] ec,
                                input logic [3:0] ee);
        vec_t v;
        v.sof = sof; v.pau = pau; v.rl = rl; v.bdr = bdr;
        v.x = 6'(x); v.y = 6'(y); v.dr = dr; v.ec = ec; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        startOfFrame       = v.sof;
        pause              = v.pau;
        reset_level        = v.rl;
        ballDrawingRequest = v.bdr;
        ballOffsetX        = v.x;
        ballOffsetY        = v.y;
        {creditDR, bumperDR, flipperDR,
         springDR, obstacleDR, frameDR} = v.dr;
    endtask

    task automatic check(input string nm, input logic [5:0] ec,
                         input logic [3:0] ee);
        n_vec++;
        if (act !== ec || coll.hitEdgeCode !== ee) begin
            n_err++;
            $display("FAIL %s: coll=%b edge=%b, expected coll=%b edge=%b",
                     nm, act, coll.hitEdgeCode, ec, ee);
        end
    endtask

    // Inputs hold for one cycle; outputs are checked mid-cycle.
    task automatic run(input vec_t v, input string nm);
        drive(v);
        @(negedge clk);
        check(nm, v.ec, v.ee);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input vec_t v, input int cycles);
        drive(v);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 3 cycles after reset, all classes overlapping at an interior pixel
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, 1, 8, 8, 6'h3F, 6'h00, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 1, 8, 8, 6'h3F, 6'h00, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h3F, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0000));
        // bottom-edge flipper hit
        for (int x = 6; x <= 9; x++)
            tbl.push_back(mk(0, 0, 0, 1, x, 15, 6'h08, 6'h00, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h08, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0001));
        // bumper: one pixel is below threshold, two is a hit
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 6'h10, 6'h00, 4'b0001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 6'h10, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 6'h10, 6'h00, 4'b0001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h10, 4'b1100));
        // credit on right (incl. offset beyond sprite), obstacle on top
        tbl.push_back(mk(0, 0, 0, 1, 15, 8, 6'h20, 6'h00, 4'b1100));
        tbl.push_back(mk(0, 0, 0, 1, 40, 8, 6'h20, 6'h00, 4'b1100));
        tbl.push_back(mk(0, 0, 0, 1, 8, 0, 6'h02, 6'h00, 4'b1100));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 6'h02, 6'h00, 4'b1100));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b1100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h22, 4'b0100));
        // pause across startOfFrame holds the counts
        tbl.push_back(mk(0, 0, 0, 1, 8, 15, 6'h01, 6'h00, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 9, 15, 6'h01, 6'h00, 4'b0100));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0100));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h01, 4'b0001));
        // pause in the output cycle suppresses the pulse
        tbl.push_back(mk(0, 0, 0, 1, 0, 8, 6'h01, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8, 6'h01, 6'h00, 4'b0001));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0001));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 6'h00, 6'h00, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b1000));
        // back-to-back startOfFrame: second emit overwrites with nothing
        tbl.push_back(mk(0, 0, 0, 1, 8, 0, 6'h04, 6'h00, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 6'h04, 6'h00, 4'b1000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b1000));
        tbl.push_back(mk(1, 0, 0, 1, 8, 0, 6'h04, 6'h04, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0100));
        // reset_level mid-frame wipes counts and edge code
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 1, 15, 15, 6'h04, 6'h00, 4'b0100));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 6'h00, 6'h00, 4'b0100));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0000));

        // reset held 2 cycles with every request active
        resetN = 1'b0;
        drive(mk(0, 0, 0, 1, 0, 0, 6'h3F, 6'h00, 4'b0000));
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", 6'h00, 4'b0000);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

        // 300 overlaps: saturating count still hits
        feed(mk(0, 0, 0, 1, 0, 15, 6'h08, 6'h00, 4'b0000), 300);
        run(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0000), "sat300_sof");
        run(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h08, 4'b1001), "sat300_pulse");
        // 257 overlaps: a wrapping counter would read 1 and miss
        feed(mk(0, 0, 0, 1, 15, 0, 6'h10, 6'h00, 4'b1001), 257);
        run(mk(1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b1001), "sat257_sof");
        run(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h10, 4'b0110), "sat257_pulse");
        run(mk(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 4'b0110), "sat257_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
